// File: rtl/change_dispenser.sv
// Coin change dispenser: pays out an amount in cents as greedy quarter/dime/nickel pulses.
// Optional tube tracking (counts, availability, refill) is enabled by CHANGE_DISPENSER_STOCK_EN.
module change_dispenser #(
  parameter int PULSE_GAP = 2,
  parameter int Q_INIT    = 20,
  parameter int D_INIT    = 20,
  parameter int N_INIT    = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] amount,
  input  logic       refill,
  output logic       quarter,
  output logic       dime,
  output logic       nickel,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [8:0] remaining,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_PULSE  = 3'd2,
    S_GAP    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    C_NONE = 2'd0,
    C_Q    = 2'd1,
    C_D    = 2'd2,
    C_N    = 2'd3
  } coin_t;

  state_t     state_q, state_d;
  coin_t      coin_q, coin_d, coin_sel;
  logic [8:0] rem_q, rem_d;
  logic       err_q, err_d;
  logic [3:0] gap_q, gap_d;
  logic [8:0] coin_val;
  logic       q_avail, d_avail, n_avail;

`ifdef CHANGE_DISPENSER_STOCK_EN
  logic [5:0] q_cnt_q, q_cnt_d;
  logic [5:0] d_cnt_q, d_cnt_d;
  logic [5:0] n_cnt_q, n_cnt_d;

  assign q_avail = (q_cnt_q != 6'd0);
  assign d_avail = (d_cnt_q != 6'd0);
  assign n_avail = (n_cnt_q != 6'd0);

  // Refill only in IDLE; it lands on the same edge as a start, so the payout sees fresh counts.
  always_comb begin
    q_cnt_d = q_cnt_q;
    d_cnt_d = d_cnt_q;
    n_cnt_d = n_cnt_q;
    if (state_q == S_IDLE && refill) begin
      q_cnt_d = 6'(Q_INIT);
      d_cnt_d = 6'(D_INIT);
      n_cnt_d = 6'(N_INIT);
    end else if (state_q == S_PULSE) begin
      case (coin_q)
        C_Q:     q_cnt_d = q_cnt_q - 6'd1;
        C_D:     d_cnt_d = d_cnt_q - 6'd1;
        C_N:     n_cnt_d = n_cnt_q - 6'd1;
        default: ;
      endcase
    end
  end
`else
  logic       unused_refill;
  logic [5:0] unused_init;

  assign q_avail       = 1'b1;
  assign d_avail       = 1'b1;
  assign n_avail       = 1'b1;
  assign unused_refill = refill;
  assign unused_init   = 6'(Q_INIT) ^ 6'(D_INIT) ^ 6'(N_INIT);
`endif

  // Greedy choice; a coin is only picked when remaining covers it, so the subtract cannot wrap.
  always_comb begin
    coin_sel = C_NONE;
    if (rem_q >= 9'd25 && q_avail)      coin_sel = C_Q;
    else if (rem_q >= 9'd10 && d_avail) coin_sel = C_D;
    else if (rem_q >= 9'd5 && n_avail)  coin_sel = C_N;
  end

  always_comb begin
    case (coin_q)
      C_Q:     coin_val = 9'd25;
      C_D:     coin_val = 9'd10;
      C_N:     coin_val = 9'd5;
      default: coin_val = 9'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      coin_q  <= C_NONE;
      rem_q   <= 9'd0;
      err_q   <= 1'b0;
      gap_q   <= 4'd0;
`ifdef CHANGE_DISPENSER_STOCK_EN
      q_cnt_q <= 6'(Q_INIT);
      d_cnt_q <= 6'(D_INIT);
      n_cnt_q <= 6'(N_INIT);
`endif
    end else begin
      state_q <= state_d;
      coin_q  <= coin_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      gap_q   <= gap_d;
`ifdef CHANGE_DISPENSER_STOCK_EN
      q_cnt_q <= q_cnt_d;
      d_cnt_q <= d_cnt_d;
      n_cnt_q <= n_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    coin_d  = coin_q;
    rem_d   = rem_q;
    err_d   = err_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d = amount;
          err_d = 1'b0;
          if ((amount % 9'd5) != 9'd0) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_SELECT;
          end
        end
      end
      S_SELECT: begin
        if (rem_q == 9'd0) begin
          state_d = S_DONE;
        end else if (coin_sel == C_NONE) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          coin_d  = coin_sel;
          state_d = S_PULSE;
        end
      end
      S_PULSE: begin
        rem_d   = rem_q - coin_val;
        gap_d   = 4'(PULSE_GAP - 1);
        state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_q == 4'd0) state_d = S_SELECT;
        else               gap_d   = gap_q - 4'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Coin pulses decode the registered choice only in PULSE, so they are one-hot and glitch-safe.
  always_comb begin
    quarter   = (state_q == S_PULSE) && (coin_q == C_Q);
    dime      = (state_q == S_PULSE) && (coin_q == C_D);
    nickel    = (state_q == S_PULSE) && (coin_q == C_N);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    error     = err_q;
    remaining = rem_q;
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: greedy coin scoreboard, payout timing, reset abort, ignored restart.
module tb_change_dispenser;
  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       reset, start, refill;
  logic [8:0] amount;
  logic       quarter, dime, nickel, busy, done, error;
  logic [8:0] remaining;
  logic [2:0] state_dbg;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int start_cyc = 0;
  logic [1:0] exp_q[$];
  int pulse_rel[$];
  logic [1:0] mon_code;

  change_dispenser #(.PULSE_GAP(GAP)) dut (
    .clk(clk), .reset(reset), .start(start), .amount(amount), .refill(refill),
    .quarter(quarter), .dime(dime), .nickel(nickel), .busy(busy), .done(done),
    .error(error), .remaining(remaining), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Coin scoreboard: every pulse must be one-hot, inside a payout, and match the next expected coin.
  always @(negedge clk) begin
    if (!reset && (quarter || dime || nickel)) begin
      mon_code = quarter ? 2'd1 : (dime ? 2'd2 : 2'd3);
      check("coin_onehot", 32'(quarter) + 32'(dime) + 32'(nickel), 32'd1);
      check("coin_busy", 32'(busy), 32'd1);
      pulse_rel.push_back(cyc - start_cyc);
      if (exp_q.size() == 0) check("coin_unexpected", 32'(mon_code), 32'd0);
      else check("coin_order", 32'(mon_code), 32'(exp_q.pop_front()));
    end
  end

  // Greedy model with unlimited tubes; returns coin count, or -1 for a rejected amount.
  function automatic int model(input int amt);
    int r, n;
    if (amt % 5 != 0) return -1;
    r = amt;
    n = 0;
    while (r >= 25) begin exp_q.push_back(2'd1); r -= 25; n++; end
    while (r >= 10) begin exp_q.push_back(2'd2); r -= 10; n++; end
    while (r >= 5)  begin exp_q.push_back(2'd3); r -= 5;  n++; end
    return n;
  endfunction

  task automatic pay(input logic [8:0] amt, input logic do_refill, input logic poke, input string tag);
    int   n, exp_rel, rel, extra_done, extra_busy;
    logic got, exp_err;
    @(negedge clk);
    pulse_rel.delete();
    amount    = amt;
    start     = 1'b1;
    refill    = do_refill;
    start_cyc = cyc;
    n       = model(int'(amt));
    exp_err = (n < 0);
    exp_rel = exp_err ? 1 : 2 + n * (2 + GAP);
    @(negedge clk);
    start  = 1'b0;
    refill = 1'b0;
    got    = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (poke && i == 2) begin start = 1'b1; amount = 9'd100; end
      if (poke && i == 3) start = 1'b0;
      if (done) begin got = 1'b1; break; end
      @(negedge clk);
    end
    rel = cyc - start_cyc;
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_done_cycle"}, 32'(rel), 32'(exp_rel));
    check({tag, "_error"}, 32'(error), 32'(exp_err));
    check({tag, "_remaining"}, 32'(remaining), exp_err ? 32'(amt) : 32'd0);
    check({tag, "_pulses"}, 32'(pulse_rel.size()), exp_err ? 32'd0 : 32'(n));
    check({tag, "_coins_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    extra_done = 0;
    extra_busy = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      extra_done += int'(done);
      extra_busy += int'(busy);
    end
    check({tag, "_extra_done"}, 32'(extra_done), 32'd0);
    check({tag, "_idle_busy"}, 32'(extra_busy), 32'd0);
    check({tag, "_error_hold"}, 32'(error), 32'(exp_err));
    check({tag, "_rem_hold"}, 32'(remaining), exp_err ? 32'(amt) : 32'd0);
  endtask

`ifdef CHANGE_DISPENSER_STOCK_EN
  logic       s_start, s_refill;
  logic [8:0] s_amount;
  logic       s_quarter, s_dime, s_nickel, s_busy, s_done, s_error;
  logic [8:0] s_remaining;
  logic [2:0] s_state_dbg;
  int         s_qn = 0, s_dn = 0, s_nn = 0;

  change_dispenser #(.PULSE_GAP(GAP), .Q_INIT(1), .D_INIT(0), .N_INIT(1)) dut_stock (
    .clk(clk), .reset(reset), .start(s_start), .amount(s_amount), .refill(s_refill),
    .quarter(s_quarter), .dime(s_dime), .nickel(s_nickel), .busy(s_busy), .done(s_done),
    .error(s_error), .remaining(s_remaining), .state_dbg(s_state_dbg)
  );

  always @(negedge clk) begin
    s_qn += int'(s_quarter);
    s_dn += int'(s_dime);
    s_nn += int'(s_nickel);
  end

  task automatic pay_stock(input logic [8:0] amt, input logic do_refill, input string tag);
    logic got;
    @(negedge clk);
    s_amount = amt;
    s_start  = 1'b1;
    s_refill = do_refill;
    @(negedge clk);
    s_start  = 1'b0;
    s_refill = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (s_done) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
  endtask
`endif

  initial begin
    int done_cnt, busy_cnt;
    logic got;
    reset  = 1'b1;
    start  = 1'b0;
    refill = 1'b0;
    amount = 9'd0;
`ifdef CHANGE_DISPENSER_STOCK_EN
    s_start  = 1'b0;
    s_refill = 1'b0;
    s_amount = 9'd0;
`endif
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_remaining", 32'(remaining), 32'd0);
    check("rst_coins", 32'({quarter, dime, nickel}), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    reset = 1'b0;

    pay(9'd30, 1'b0, 1'b0, "s1");
    check("s1_quarter_cycle", 32'(pulse_rel[0]), 32'd2);
    check("s1_nickel_cycle", 32'(pulse_rel[1]), 32'd6);
    pay(9'd0,   1'b0, 1'b0, "s2");
    pay(9'd37,  1'b0, 1'b0, "s3");
    pay(9'd65,  1'b0, 1'b0, "mix65");
    pay(9'd30,  1'b1, 1'b0, "refill_start");
    pay(9'd511, 1'b0, 1'b0, "max511");
    pay(9'd510, 1'b0, 1'b0, "max510");
    pay(9'(5 * $urandom_range(1, 60)), 1'b0, 1'b0, "rand_ok");
    pay(9'(5 * $urandom_range(0, 100) + $urandom_range(1, 4)), 1'b0, 1'b0, "rand_bad");
    pay(9'd50, 1'b0, 1'b1, "s6_restart");

    // Abort a 75-cent payout during the gap after its second quarter.
    @(negedge clk);
    pulse_rel.delete();
    amount    = 9'd75;
    start     = 1'b1;
    start_cyc = cyc;
    void'(model(75));
    @(negedge clk);
    start = 1'b0;
    got   = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (pulse_rel.size() >= 2) begin got = 1'b1; break; end
    end
    check("s5_two_pulses", 32'(got), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("s5_busy", 32'(busy), 32'd0);
    check("s5_done", 32'(done), 32'd0);
    check("s5_error", 32'(error), 32'd0);
    check("s5_remaining", 32'(remaining), 32'd0);
    check("s5_coins", 32'({quarter, dime, nickel}), 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      done_cnt += int'(done);
      busy_cnt += int'(busy);
    end
    check("s5_no_done", 32'(done_cnt), 32'd0);
    check("s5_no_busy", 32'(busy_cnt), 32'd0);
    check("s5_pulse_total", 32'(pulse_rel.size()), 32'd2);

`ifdef CHANGE_DISPENSER_STOCK_EN
    // Tubes hold one quarter, no dimes, one nickel.
    s_qn = 0; s_dn = 0; s_nn = 0;
    pay_stock(9'd40, 1'b0, "s4a");
    check("s4a_quarters", 32'(s_qn), 32'd1);
    check("s4a_nickels", 32'(s_nn), 32'd1);
    check("s4a_dimes", 32'(s_dn), 32'd0);
    check("s4a_error", 32'(s_error), 32'd1);
    check("s4a_remaining", 32'(s_remaining), 32'd10);
    pay_stock(9'd10, 1'b1, "s4b");
    check("s4b_nickels", 32'(s_nn), 32'd2);
    check("s4b_dimes", 32'(s_dn), 32'd0);
    check("s4b_error", 32'(s_error), 32'd1);
    check("s4b_remaining", 32'(s_remaining), 32'd5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 The block SHALL have parameter PULSE_GAP, default 2, idle cycles after each coin pulse (legal range 1..15).
REQ-002 The block SHALL have parameters Q_INIT, D_INIT, N_INIT, default 20 each, the coin tube count loaded at reset or refill (legal range 0..63).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, a request to pay out amount; sampled only in IDLE.
REQ-006 The block SHALL have port amount, input, 9, change in cents (0..511).
REQ-007 The block SHALL have port refill, input, 1, which reloads tube counts; honoured only in IDLE.
REQ-008 The block SHALL have ports quarter, dime and nickel, output, 1 each, one-cycle eject pulses.
REQ-009 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-010 The block SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-011 The block SHALL have port error, output, 1, valid with done: 1 = rejected or short-paid.
REQ-012 The block SHALL have port remaining, output, 9, the cents still owed; the registered working value.

Function
REQ-013 The FSM SHALL have states IDLE, SELECT, PULSE, GAP and DONE.
REQ-014 In IDLE with start=1, the block SHALL register amount into remaining and go to SELECT on the next edge; start in any other state SHALL be ignored.
REQ-015 If amount mod 5 != 0 at start, the block SHALL go directly to DONE with error=1, remaining=amount, and eject no coins.
REQ-016 SELECT coin choice SHALL be greedy, first match wins:
- quarter if remaining>=25 and quarters are available;
- else dime if remaining>=10 and dimes are available;
- else nickel if remaining>=5 and nickels are available.
REQ-017 SELECT with remaining=0 SHALL go to DONE with error=0.
REQ-018 SELECT with remaining>0 and no coin choosable SHALL go to DONE with error=1, leaving remaining unchanged.
REQ-019 In PULSE, exactly one of quarter/dime/nickel SHALL be high for one cycle, remaining SHALL decrease by the coin value, and the matching tube count SHALL decrement.
REQ-020 GAP SHALL last exactly PULSE_GAP cycles, with all coin outputs low, then return to SELECT.
REQ-021 DONE SHALL last one cycle with done=1, then go to IDLE; error and remaining SHALL hold until the next start.
REQ-022 Coin outputs SHALL never be high together, and SHALL never be high outside PULSE.
REQ-023 Per-coin latency SHALL be SELECT(1) + PULSE(1) + GAP(PULSE_GAP) cycles; the first pulse SHALL occur 2 cycles after the start edge.
REQ-024 start and refill asserted together in IDLE: refill SHALL apply first, and the payout SHALL use the refilled counts.
REQ-025 Subtraction SHALL never underflow, because a coin is chosen only when remaining >= its value.

Reset
REQ-026 Asserting reset SHALL, asynchronously and regardless of state, force:
- the FSM to IDLE;
- quarter, dime, nickel, busy, done and error to 0;
- remaining to 0;
- tube counts to Q_INIT/D_INIT/N_INIT.
REQ-027 A reset during a payout SHALL abort it; no further pulses SHALL occur and no done SHALL be issued.

Configuration
REQ-028 Macro CHANGE_DISPENSER_STOCK_EN SHALL control tube tracking.
- Defined: 6-bit tube counters exist, REQ-016 availability checks apply, and refill is functional.
- Undefined: all coins are always available, there are no counters, refill is ignored, and error is set only by REQ-015.

Verification
REQ-029 Scenario 1: amount=30, start, PULSE_GAP=2 -> quarter at cycle 2, nickel at cycle 6, done at cycle 10, error=0, remaining=0.
REQ-030 Scenario 2: amount=0, start -> done 2 cycles after start, no coin pulses, error=0.
REQ-031 Scenario 3: amount=37 -> done 1 cycle after start, error=1, remaining=37, no coin pulses.
REQ-032 Scenario 4: STOCK_EN defined, Q_INIT=1, D_INIT=0, N_INIT=1, amount=40 -> one quarter, one nickel, done with error=1, remaining=10; then refill and amount=10 -> one nickel, done with error=1, remaining=5 (D_INIT=0).
REQ-033 Scenario 5: amount=75; reset asserted after the 2nd quarter pulse -> outputs zero immediately, no 3rd pulse, no done, busy=0.
REQ-034 Scenario 6: a second start pulse while busy during amount=50 -> ignored; exactly two quarters are ejected and one done is issued.
